// File: rtl/id_stage.sv
// id_stage: decode / operand-read stage of the 16-bit five-stage pipeline.
// Owns the 8x16 general register file, writes it from WB, forwards
// in-flight results from EX, MEM and WB, and registers ex_ir, reg_A,
// reg_B and smdr for the execute stage.
// Optional build macro: ID_DEBUG_PORT_EN adds select_y / y, an
// unforwarded combinational view of one register for the board display.
module id_stage #(
  parameter int NREG = 8,
  parameter int DW   = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          state,
  input  logic [DW-1:0] id_ir,
  input  logic [DW-1:0] ex_result,
  input  logic [DW-1:0] mem_ir,
  input  logic [DW-1:0] reg_C,
  input  logic [DW-1:0] wb_ir,
  input  logic [DW-1:0] reg_C1,
`ifdef ID_DEBUG_PORT_EN
  input  logic [2:0]    select_y,
  output logic [DW-1:0] y,
`endif
  output logic [DW-1:0] ex_ir,
  output logic [DW-1:0] reg_A,
  output logic [DW-1:0] reg_B,
  output logic [DW-1:0] smdr
);

  // CPU run state that lets the pipeline advance
  localparam logic EXEC = 1'b1;

  // Opcode map of the instruction set
  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_HALT  = 5'b00001;
  localparam logic [4:0] OP_LOAD  = 5'b00010;
  localparam logic [4:0] OP_STORE = 5'b00011;
  localparam logic [4:0] OP_SLL   = 5'b00100;
  localparam logic [4:0] OP_SLA   = 5'b00101;
  localparam logic [4:0] OP_SRL   = 5'b00110;
  localparam logic [4:0] OP_SRA   = 5'b00111;
  localparam logic [4:0] OP_ADD   = 5'b01000;
  localparam logic [4:0] OP_ADDI  = 5'b01001;
  localparam logic [4:0] OP_SUB   = 5'b01010;
  localparam logic [4:0] OP_SUBI  = 5'b01011;
  localparam logic [4:0] OP_CMP   = 5'b01100;
  localparam logic [4:0] OP_AND   = 5'b01101;
  localparam logic [4:0] OP_OR    = 5'b01110;
  localparam logic [4:0] OP_XOR   = 5'b01111;
  localparam logic [4:0] OP_LDIH  = 5'b10000;
  localparam logic [4:0] OP_ADDC  = 5'b10001;
  localparam logic [4:0] OP_SUBC  = 5'b10010;
  localparam logic [4:0] OP_JUMP  = 5'b11000;
  localparam logic [4:0] OP_JMPR  = 5'b11001;
  localparam logic [4:0] OP_BZ    = 5'b11010;
  localparam logic [4:0] OP_BNZ   = 5'b11011;
  localparam logic [4:0] OP_BN    = 5'b11100;
  localparam logic [4:0] OP_BNN   = 5'b11101;
  localparam logic [4:0] OP_BC    = 5'b11110;
  localparam logic [4:0] OP_BNC   = 5'b11111;

  // True when the instruction writes its r1 field back to the register file
  function automatic logic writes_reg(input logic [4:0] op);
    logic w;
    w = 1'b0;
    case (op)
      OP_LOAD, OP_LDIH,
      OP_ADD, OP_ADDI, OP_ADDC,
      OP_SUB, OP_SUBI, OP_SUBC,
      OP_AND, OP_OR, OP_XOR,
      OP_SLL, OP_SRL, OP_SLA, OP_SRA: w = 1'b1;
      default:                        w = 1'b0;
    endcase
    return w;
  endfunction

  logic [DW-1:0] gr [NREG];

  logic [4:0]    id_op;
  logic [2:0]    id_r1, id_r2, id_r3;
  logic [DW-1:0] val3_ext, imm8_ext, imm8_hi;

  logic          ex_wr, mem_wr, wb_wr;
  logic [2:0]    rd_idx [3];
  logic [DW-1:0] rd_val [3];

  logic [DW-1:0] nxt_a, nxt_b, nxt_smdr;

  // Only the opcode and destination fields of MEM/WB instructions matter here
  logic          unused_bits;
  assign unused_bits = ^{mem_ir[7:0], wb_ir[7:0]};

  assign id_op = id_ir[15:11];
  assign id_r1 = id_ir[10:8];
  assign id_r2 = id_ir[6:4];
  assign id_r3 = id_ir[2:0];

  assign val3_ext = {{(DW-4){1'b0}}, id_ir[3:0]};
  assign imm8_ext = {{(DW-8){1'b0}}, id_ir[7:0]};
  assign imm8_hi  = {id_ir[7:0], {(DW-8){1'b0}}};

  // A LOAD in EX has no data yet; fetch already bubbled the dependent op,
  // so it must never be forwarded from ex_result.
  assign ex_wr  = writes_reg(ex_ir[15:11]) && (ex_ir[15:11] != OP_LOAD);
  assign mem_wr = writes_reg(mem_ir[15:11]);
  assign wb_wr  = writes_reg(wb_ir[15:11]);

  // Three read ports: 0 = r2 (or r1 for immediate forms), 1 = r3, 2 = r1
  always_comb begin
    rd_idx[0] = id_r2;
    rd_idx[1] = id_r3;
    rd_idx[2] = id_r1;
    case (id_op)
      OP_ADDI, OP_SUBI, OP_JMPR, OP_LDIH,
      OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC: rd_idx[0] = id_r1;
      default:                                     rd_idx[0] = id_r2;
    endcase
  end

  // Forwarding mux per port: later assignments win, giving EX > MEM > WB > file.
  // The WB leg also covers a register written and read on the same edge.
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rd_val[p] = gr[rd_idx[p]];
      if (wb_wr  && (wb_ir[10:8]  == rd_idx[p])) rd_val[p] = reg_C1;
      if (mem_wr && (mem_ir[10:8] == rd_idx[p])) rd_val[p] = reg_C;
      if (ex_wr  && (ex_ir[10:8]  == rd_idx[p])) rd_val[p] = ex_result;
    end
  end

  // Operand selection by opcode; a bubble (all-zero word) decodes as NOP
  always_comb begin
    nxt_a    = '0;
    nxt_b    = '0;
    nxt_smdr = '0;
    case (id_op)
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC,
      OP_CMP, OP_AND, OP_OR, OP_XOR: begin
        nxt_a = rd_val[0];
        nxt_b = rd_val[1];
      end
      OP_SLL, OP_SRL, OP_SLA, OP_SRA, OP_LOAD: begin
        nxt_a = rd_val[0];
        nxt_b = val3_ext;
      end
      OP_STORE: begin
        nxt_a    = rd_val[0];
        nxt_b    = val3_ext;
        nxt_smdr = rd_val[2];
      end
      OP_ADDI, OP_SUBI, OP_JMPR,
      OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC: begin
        nxt_a = rd_val[0];
        nxt_b = imm8_ext;
      end
      OP_LDIH: begin
        nxt_a = rd_val[0];
        nxt_b = imm8_hi;
      end
      OP_JUMP, OP_NOP, OP_HALT: begin
        nxt_a = '0;
        nxt_b = '0;
      end
      default: begin
        nxt_a = '0;
        nxt_b = '0;
      end
    endcase
  end

  // Pipeline register toward EX; holds whenever the CPU is not running
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_ir <= '0;
      reg_A <= '0;
      reg_B <= '0;
      smdr  <= '0;
    end else if (state == EXEC) begin
      ex_ir <= id_ir;
      reg_A <= nxt_a;
      reg_B <= nxt_b;
      smdr  <= nxt_smdr;
    end
  end

  // Register file write port driven by writeback
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) gr[i] <= '0;
    end else if ((state == EXEC) && wb_wr) begin
      gr[wb_ir[10:8]] <= reg_C1;
    end
  end

`ifdef ID_DEBUG_PORT_EN
  // Raw file contents for the board display, deliberately unforwarded
  assign y = gr[select_y];
`endif

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed vector table, hand-written
// hold/reset sequences, then randomized stimulus against a reference model.
module tb_id_stage;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_HALT  = 5'b00001;
  localparam logic [4:0] OP_LOAD  = 5'b00010;
  localparam logic [4:0] OP_STORE = 5'b00011;
  localparam logic [4:0] OP_SLL   = 5'b00100;
  localparam logic [4:0] OP_SLA   = 5'b00101;
  localparam logic [4:0] OP_SRL   = 5'b00110;
  localparam logic [4:0] OP_SRA   = 5'b00111;
  localparam logic [4:0] OP_ADD   = 5'b01000;
  localparam logic [4:0] OP_ADDI  = 5'b01001;
  localparam logic [4:0] OP_SUB   = 5'b01010;
  localparam logic [4:0] OP_SUBI  = 5'b01011;
  localparam logic [4:0] OP_CMP   = 5'b01100;
  localparam logic [4:0] OP_AND   = 5'b01101;
  localparam logic [4:0] OP_OR    = 5'b01110;
  localparam logic [4:0] OP_XOR   = 5'b01111;
  localparam logic [4:0] OP_LDIH  = 5'b10000;
  localparam logic [4:0] OP_ADDC  = 5'b10001;
  localparam logic [4:0] OP_SUBC  = 5'b10010;
  localparam logic [4:0] OP_JUMP  = 5'b11000;
  localparam logic [4:0] OP_JMPR  = 5'b11001;
  localparam logic [4:0] OP_BZ    = 5'b11010;
  localparam logic [4:0] OP_BNZ   = 5'b11011;
  localparam logic [4:0] OP_BN    = 5'b11100;
  localparam logic [4:0] OP_BNN   = 5'b11101;
  localparam logic [4:0] OP_BC    = 5'b11110;
  localparam logic [4:0] OP_BNC   = 5'b11111;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        state = 1'b0;
  logic [15:0] id_ir = '0, ex_result = '0, mem_ir = '0, reg_C = '0;
  logic [15:0] wb_ir = '0, reg_C1 = '0;
  logic [15:0] ex_ir, reg_A, reg_B, smdr;
`ifdef ID_DEBUG_PORT_EN
  logic [2:0]  select_y = '0;
  logic [15:0] y;
`endif

  id_stage dut (
    .clock     (clock),
    .reset     (reset),
    .state     (state),
    .id_ir     (id_ir),
    .ex_result (ex_result),
    .mem_ir    (mem_ir),
    .reg_C     (reg_C),
    .wb_ir     (wb_ir),
    .reg_C1    (reg_C1),
`ifdef ID_DEBUG_PORT_EN
    .select_y  (select_y),
    .y         (y),
`endif
    .ex_ir     (ex_ir),
    .reg_A     (reg_A),
    .reg_B     (reg_B),
    .smdr      (smdr)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] e_ex, input logic [15:0] e_a,
                         input logic [15:0] e_b, input logic [15:0] e_s);
    chk({tag, ".ex_ir"}, ex_ir, e_ex);
    chk({tag, ".reg_A"}, reg_A, e_a);
    chk({tag, ".reg_B"}, reg_B, e_b);
    chk({tag, ".smdr"},  smdr,  e_s);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] rrr(input logic [4:0] op, input logic [2:0] a,
                                      input logic [2:0] b, input logic [2:0] c);
    return {op, a, 1'b0, b, 1'b0, c};
  endfunction
  function automatic logic [15:0] riv(input logic [4:0] op, input logic [2:0] a,
                                      input logic [2:0] b, input logic [3:0] v);
    return {op, a, 1'b0, b, v};
  endfunction
  function automatic logic [15:0] ri(input logic [4:0] op, input logic [2:0] a,
                                     input logic [7:0] imm);
    return {op, a, imm};
  endfunction

  typedef struct {
    logic [15:0] id, exr, mir, rc, wir, rc1;
    logic [15:0] e_ex, e_a, e_b, e_s;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] id, input logic [15:0] exr,
                              input logic [15:0] mir, input logic [15:0] rc,
                              input logic [15:0] wir, input logic [15:0] rc1,
                              input logic [15:0] e_a, input logic [15:0] e_b,
                              input logic [15:0] e_s);
    vec_t v;
    v.id = id; v.exr = exr; v.mir = mir; v.rc = rc; v.wir = wir; v.rc1 = rc1;
    v.e_ex = id; v.e_a = e_a; v.e_b = e_b; v.e_s = e_s;
    return v;
  endfunction

  // ---------------- reference model ----------------
  localparam logic [4:0] WRITERS [15] = '{OP_LOAD, OP_LDIH, OP_ADD, OP_ADDI, OP_ADDC,
                                          OP_SUB, OP_SUBI, OP_SUBC, OP_AND, OP_OR,
                                          OP_XOR, OP_SLL, OP_SRL, OP_SLA, OP_SRA};
  logic [15:0] m_gr [8];
  logic [15:0] m_ex, m_a, m_b, m_s;

  function automatic bit m_writes(input logic [15:0] ir, input logic [2:0] n);
    for (int i = 0; i < 15; i++)
      if (ir[15:11] == WRITERS[i]) return ir[10:8] == n;
    return 1'b0;
  endfunction

  function automatic logic [15:0] m_read(input logic [2:0] n);
    if (m_ex[15:11] != OP_LOAD && m_writes(m_ex, n)) return ex_result;
    if (m_writes(mem_ir, n)) return reg_C;
    if (m_writes(wb_ir, n))  return reg_C1;
    return m_gr[n];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_gr[i] = '0;
    m_ex = '0; m_a = '0; m_b = '0; m_s = '0;
  endtask

  task automatic m_step();
    logic [4:0]  op;
    logic [2:0]  r1, r2, r3;
    logic [15:0] na, nb, ns;
    if (state !== 1'b1) return;
    op = id_ir[15:11]; r1 = id_ir[10:8]; r2 = id_ir[6:4]; r3 = id_ir[2:0];
    na = 0; nb = 0; ns = 0;
    if (op inside {OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP, OP_AND, OP_OR, OP_XOR}) begin
      na = m_read(r2); nb = m_read(r3);
    end else if (op inside {OP_SLL, OP_SRL, OP_SLA, OP_SRA, OP_LOAD, OP_STORE}) begin
      na = m_read(r2); nb = 16'(id_ir[3:0]);
      if (op == OP_STORE) ns = m_read(r1);
    end else if (op inside {OP_ADDI, OP_SUBI, OP_JMPR, OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC}) begin
      na = m_read(r1); nb = 16'(id_ir[7:0]);
    end else if (op == OP_LDIH) begin
      na = m_read(r1); nb = 16'(id_ir[7:0]) * 16'd256;
    end
    for (int n = 0; n < 8; n++)
      if (m_writes(wb_ir, 3'(n))) m_gr[n] = reg_C1;
    m_ex = id_ir; m_a = na; m_b = nb; m_s = ns;
  endtask

  vec_t tbl[$];
  logic [15:0] unk;
  vec_t last;

  initial begin
    unk = 16'h9FFF;  // opcode 10011: unassigned
    tbl.push_back(mk(rrr(OP_ADD,2,1,1), 0, 0, 0, ri(OP_ADDI,1,0), 16'h1234, 16'h1234, 16'h1234, 0));
    tbl.push_back(mk(16'h0000, 0, 0, 0, rrr(OP_ADD,5,0,0), 16'hBEEF, 0, 0, 0));
    tbl.push_back(mk(riv(OP_STORE,5,6,7), 0, 0, 0, rrr(OP_SUB,6,0,0), 16'h0010, 16'h0010, 16'h0007, 16'hBEEF));
    tbl.push_back(mk(ri(OP_LDIH,2,8'h3C), 0, 0, 0, 0, 0, 0, 16'h3C00, 0));
    tbl.push_back(mk(ri(OP_BZ,1,8'h20), 0, 0, 0, 0, 0, 16'h1234, 16'h0020, 0));
    tbl.push_back(mk(ri(OP_ADDI,3,8'h05), 0, 0, 0, 0, 0, 0, 16'h0005, 0));
    tbl.push_back(mk(rrr(OP_SUB,4,3,0), 16'h00AA, rrr(OP_ADD,3,0,0), 16'h0055,
                     rrr(OP_ADD,3,0,0), 16'h0077, 16'h00AA, 0, 0));
    tbl.push_back(mk(rrr(OP_AND,7,3,3), 16'h1111, rrr(OP_ADD,3,0,0), 16'h0055, 0, 0,
                     16'h0055, 16'h0055, 0));
    tbl.push_back(mk(rrr(OP_OR,7,3,1), 16'h2222, 0, 0, 0, 0, 16'h0077, 16'h1234, 0));
    tbl.push_back(mk(riv(OP_SRA,1,3,4'hF), 16'h3333, 0, 0, 0, 0, 16'h0077, 16'h000F, 0));
    tbl.push_back(mk(unk, 0, 0, 0, {5'b10011, 3'd7, 8'h00}, 16'hDEAD, 0, 0, 0));
    tbl.push_back(mk(rrr(OP_XOR,0,7,7), 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk({OP_JUMP, 11'h7FF}, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(rrr(OP_ADD,0,2,2), 0, 0, 0, rrr(OP_CMP,2,0,0), 16'h9999, 0, 0, 0));
    tbl.push_back(mk(riv(OP_LOAD,2,1,3), 0, 0, 0, 0, 0, 16'h1234, 16'h0003, 0));
    tbl.push_back(mk(rrr(OP_ADD,0,2,2), 16'hFFFF, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(riv(OP_STORE,1,3,0), 0, 0, 0, 0, 0, 16'h0077, 0, 16'h1234));

    // reset state
    #12;
    chk_all("reset", 0, 0, 0, 0);
    reset = 1'b1;
    state = 1'b1;

    foreach (tbl[i]) begin
      id_ir = tbl[i].id; ex_result = tbl[i].exr; mem_ir = tbl[i].mir;
      reg_C = tbl[i].rc; wb_ir = tbl[i].wir; reg_C1 = tbl[i].rc1;
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].e_ex, tbl[i].e_a, tbl[i].e_b, tbl[i].e_s);
    end
    last = tbl[tbl.size()-1];

    // hold: a WB write offered only while stalled must not land
    state = 1'b0; ex_result = 0; mem_ir = 0; reg_C = 0;
    wb_ir = rrr(OP_ADD,5,0,0); reg_C1 = 16'h5555; id_ir = rrr(OP_OR,7,1,1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all("hold1", last.e_ex, last.e_a, last.e_b, last.e_s);
    end
    state = 1'b1; wb_ir = 0; reg_C1 = 0; id_ir = rrr(OP_ADD,0,5,5);
    tick();
    chk_all("hold1_resume", rrr(OP_ADD,0,5,5), 16'hBEEF, 16'hBEEF, 0);

    // hold: pending write lands on the first exec edge
    state = 1'b0; wb_ir = rrr(OP_SUB,4,0,0); reg_C1 = 16'h4444; id_ir = rrr(OP_XOR,1,4,4);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all("hold2", rrr(OP_ADD,0,5,5), 16'hBEEF, 16'hBEEF, 0);
    end
    state = 1'b1;
    tick();
    chk_all("hold2_edge", rrr(OP_XOR,1,4,4), 16'h4444, 16'h4444, 0);
    wb_ir = 0; reg_C1 = 0; id_ir = rrr(OP_AND,2,4,6);
    tick();
    chk_all("hold2_file", rrr(OP_AND,2,4,6), 16'h4444, 16'h0010, 0);

    // asynchronous reset mid-run with a pending write
    wb_ir = rrr(OP_ADD,4,0,0); reg_C1 = 16'hAAAA; id_ir = riv(OP_STORE,4,6,1);
    #2 reset = 1'b0;
    #1 chk_all("async_rst", 0, 0, 0, 0);
`ifdef ID_DEBUG_PORT_EN
    for (int r = 0; r < 8; r++) begin
      select_y = 3'(r);
      #1 chk($sformatf("y_rst%0d", r), y, 16'h0000);
    end
`endif
    tick();
    chk_all("rst_held", 0, 0, 0, 0);
    reset = 1'b1; wb_ir = 0; reg_C1 = 0; id_ir = rrr(OP_ADD,0,4,1);
    tick();
    chk_all("post_rst", rrr(OP_ADD,0,4,1), 0, 0, 0);

    // randomized phase against the reference model
    reset = 1'b0;
    #2 reset = 1'b1;
    m_reset();
    for (int c = 0; c < 600; c++) begin
      state     = ($urandom_range(0, 4) != 0);
      id_ir     = ($urandom_range(0, 9) == 0) ? 16'h0000 : 16'($urandom);
      ex_result = 16'($urandom);
      mem_ir    = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
      reg_C     = 16'($urandom);
      wb_ir     = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
      reg_C1    = 16'($urandom);
      m_step();
      tick();
      chk_all($sformatf("rnd%0d", c), m_ex, m_a, m_b, m_s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
